aud_dsp_param: RTL and testbench
================================

AUD_DSP_PARAM -- requirements
Module: aud_dsp_param

Interface
REQ-001 Parameter DATA_W, default 16: sample width (signed two's complement).
REQ-002 Parameter ADDR_W, default 20: SRAM word-address width.
REQ-003 Parameter SPEED_W, default 3: speed field width; rate factor N = i_speed+1, range 1..2^SPEED_W.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_start  in  1  one-cycle pulse: begin playback from IDLE.
REQ-007 i_pause  in  1  one-cycle pulse: toggle pause/play.
REQ-008 i_stop  in  1  one-cycle pulse: abort to IDLE.
REQ-009 i_speed  in  SPEED_W  rate factor minus one.
REQ-010 i_is_slow  in  1  1 = slow (divide by N), 0 = fast/normal (multiply by N).
REQ-011 i_interp  in  1  slow only: 1 = linear interpolation, 0 = sample-and-hold.
REQ-012 i_reverse  in  1  1 = play from i_sram_stop_addr down to 0.
REQ-013 i_loop  in  1  1 = wrap at end of range instead of finishing.
REQ-014 i_daclrck  in  1  DAC LR clock, synchronous to i_clk; a falling edge requests one sample.
REQ-015 i_sram_data  in  DATA_W  read data, valid the cycle after o_sram_addr changes.
REQ-016 i_sram_stop_addr  in  ADDR_W  last valid recorded address.
REQ-017 o_dac_data  out  DATA_W  output sample; held between updates.
REQ-018 o_dac_valid  out  1  one-cycle strobe: o_dac_data updated this cycle.
REQ-019 o_is_pause  out  1  high exactly while in PAUSE.
REQ-020 o_done  out  1  one-cycle strobe on non-loop end of playback.
REQ-021 o_sram_addr  out  ADDR_W  SRAM read address.

Function
REQ-022 FSM states: IDLE, PAUSE, WAIT, RD0, RD1, CALC; transitions: IDLE->WAIT on i_start; WAIT->RD0 on daclrck fall; RD0->RD1->CALC->WAIT unconditionally; WAIT->PAUSE on i_pause; PAUSE->WAIT on i_pause.
REQ-023 A pause pulse received in RD0/RD1/CALC is latched and taken on the next cycle in WAIT, so the sample in flight always completes.
REQ-024 Falling-edge detect: registered previous daclrck = 1 and current = 0; a fall seen outside WAIT is dropped.
REQ-025 Config (i_speed, i_is_slow, i_interp, i_reverse, i_loop) is latched on IDLE->WAIT and on PAUSE->WAIT only; it stays constant while playing.
REQ-026 On i_start, base = 0 (forward) or i_sram_stop_addr (reverse); frac counter k = 0.
REQ-027 RD0 drives o_sram_addr = base; RD1 captures s0 and drives neighbour = base±1 toward the play direction, clamped to base at the range end; CALC captures s1.
REQ-028 CALC output: fast or hold mode -> s0; linear mode -> s0 + trunc((s1-s0)*k / N), with the divide signed and truncating toward zero.
REQ-029 Widths: diff DATA_W+1 bits; product DATA_W+SPEED_W+2 bits; the result always lies between s0 and s1, so no saturation is needed.
REQ-030 o_dac_valid pulses in the cycle o_dac_data updates: 4 cycles after the cycle where the daclrck fall is detected.
REQ-031 Advance in CALC: fast mode steps base by N; slow mode increments k, and when k = N-1 sets k = 0 and steps base by 1.
REQ-032 End of range, when the step would take base past i_sram_stop_addr (forward) or below 0 (reverse): with loop, base = 0 (forward) or i_sram_stop_addr (reverse); without loop, o_done pulses in that CALC cycle, the current sample is still output, and the next state is IDLE.
REQ-033 Priority: i_stop > i_pause > daclrck fall; i_stop in any state goes to IDLE next cycle without o_done; i_start is ignored outside IDLE.
REQ-034 i_pause in IDLE is ignored; o_sram_addr in IDLE = 0.

Reset
REQ-035 While i_rst is high at a clock edge, the FSM goes to IDLE and the following clear: base, k, s0, s1, pause latch, previous-daclrck register.
REQ-036 Output reset values: o_dac_data = 0, o_dac_valid = 0, o_is_pause = 0, o_done = 0, o_sram_addr = 0; reset mid-sample discards that sample.

Structure
REQ-037 Package aud_dsp_pkg holds the state enum, default parameter constants and a config struct {speed, is_slow, interp, reverse, loop}.
REQ-038 Sub-module aud_interp: combinational linear interpolation (s0, s1, k, N -> sample), parametrised by DATA_W and SPEED_W.

Verification
REQ-039 Normal forward: mem[i] = 100*i, stop = 9, speed = 0 -> outputs 0, 100, …, 900, then o_done, then IDLE.
REQ-040 Slow linear: N = 4, s0 = 0, s1 = 400 -> outputs 0, 100, 200, 300, then 400 at the next base; with s0 = 0, s1 = -3, k = 1 -> output 0.
REQ-041 Fast reverse loop: stop = 9, N = 3 -> addresses 9, 6, 3, 0, 9, …; o_done never pulses.
REQ-042 Pause mid-RD1 -> current sample emitted, o_is_pause rises in WAIT; further daclrck falls produce no o_dac_valid until the next i_pause.
REQ-043 i_stop and i_pause in the same cycle -> IDLE, o_is_pause = 0, no o_done; i_rst asserted in CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/aud_dsp_pkg.sv
// Shared types and default widths for the sample-playback DSP.
// The config struct is what gets frozen while a clip is playing.
package aud_dsp_pkg;

  localparam int unsigned DefDataW  = 16;
  localparam int unsigned DefAddrW  = 20;
  localparam int unsigned DefSpeedW = 3;

  // Widest SPEED_W the config struct can carry.
  localparam int unsigned CfgSpeedW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPause,
    StWait,
    StRd0,
    StRd1,
    StCalc
  } state_e;

  typedef struct packed {
    logic [CfgSpeedW-1:0] speed;
    logic                 is_slow;
    logic                 interp;
    logic                 reverse;
    logic                 loop;
  } cfg_t;

endpackage

// File: rtl/aud_interp.sv
// Linear interpolation between two neighbouring samples:
// s0 + trunc((s1 - s0) * k / N), with the divide rounding toward zero.
module aud_interp #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SPEED_W = 3
) (
  input  logic signed [DATA_W-1:0]  i_s0,
  input  logic signed [DATA_W-1:0]  i_s1,
  input  logic        [SPEED_W-1:0] i_k,
  input  logic        [SPEED_W:0]   i_n,
  output logic signed [DATA_W-1:0]  o_sample
);

  localparam int unsigned DiffW = DATA_W + 1;
  localparam int unsigned ProdW = DATA_W + SPEED_W + 2;

  logic signed [DiffW-1:0] w_diff;
  logic signed [ProdW-1:0] w_prod;
  logic signed [ProdW-1:0] w_quot;
  logic signed [ProdW-1:0] w_sum;

  always_comb begin
    w_diff = {i_s1[DATA_W-1], i_s1} - {i_s0[DATA_W-1], i_s0};
    w_prod = ProdW'(w_diff) * $signed(ProdW'(i_k));
    w_quot = w_prod / $signed(ProdW'(i_n));
    // Result is bounded by s0 and s1, so truncation back to DATA_W is exact.
    w_sum    = w_quot + ProdW'(i_s0);
    o_sample = DATA_W'(w_sum);
  end

endmodule

// File: rtl/aud_dsp_param.sv
// Sample playback engine: reads a recorded clip from SRAM one sample per DAC
// LR-clock fall, with variable speed, interpolation, reverse, loop and pause.
module aud_dsp_param
  import aud_dsp_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned SPEED_W = DefSpeedW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_stop,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_is_slow,
  input  logic               i_interp,
  input  logic               i_reverse,
  input  logic               i_loop,
  input  logic               i_daclrck,
  input  logic [DATA_W-1:0]  i_sram_data,
  input  logic [ADDR_W-1:0]  i_sram_stop_addr,
  output logic [DATA_W-1:0]  o_dac_data,
  output logic               o_dac_valid,
  output logic               o_is_pause,
  output logic               o_done,
  output logic [ADDR_W-1:0]  o_sram_addr
);

  state_e                    r_state;
  cfg_t                      r_cfg;
  cfg_t                      w_cfg_in;
  logic [ADDR_W-1:0]         r_base;
  logic [ADDR_W-1:0]         r_sram_addr;
  logic [SPEED_W-1:0]        r_k;
  logic signed [DATA_W-1:0]  r_s0;
  logic signed [DATA_W-1:0]  r_dac_data;
  logic                      r_dac_valid;
  logic                      r_done;
  logic                      r_pause_pend;
  logic                      r_lrck_prev;

  logic                      w_fall;
  logic                      w_k_wrap;
  logic                      w_end;
  logic [SPEED_W:0]          w_n;
  logic [SPEED_W-1:0]        w_k_next;
  logic [ADDR_W:0]           w_step;
  logic [ADDR_W:0]           w_fwd_sum;
  logic [ADDR_W:0]           w_rev_diff;
  logic [ADDR_W-1:0]         w_base_next;
  logic [ADDR_W-1:0]         w_nbr;
  logic signed [DATA_W-1:0]  w_interp;
  logic signed [DATA_W-1:0]  w_sample;

  always_comb begin
    w_cfg_in = '{
      speed:   CfgSpeedW'(i_speed),
      is_slow: i_is_slow,
      interp:  i_interp,
      reverse: i_reverse,
      loop:    i_loop
    };

    w_fall   = r_lrck_prev & ~i_daclrck;
    w_n      = (SPEED_W+1)'(r_cfg.speed) + (SPEED_W+1)'(1);
    w_k_wrap = (CfgSpeedW'(r_k) == r_cfg.speed);

    // Fast mode jumps N words; slow mode moves one word every N outputs.
    if (r_cfg.is_slow) begin
      w_step   = (ADDR_W+1)'(w_k_wrap);
      w_k_next = w_k_wrap ? '0 : r_k + SPEED_W'(1);
    end else begin
      w_step   = (ADDR_W+1)'(r_cfg.speed) + (ADDR_W+1)'(1);
      w_k_next = '0;
    end

    w_fwd_sum  = {1'b0, r_base} + w_step;
    w_rev_diff = {1'b0, r_base} - w_step;

    if (r_cfg.reverse) begin
      w_end = w_rev_diff[ADDR_W];
    end else begin
      w_end = w_fwd_sum > {1'b0, i_sram_stop_addr};
    end

    if (w_end) begin
      w_base_next = r_cfg.reverse ? i_sram_stop_addr : '0;
    end else if (r_cfg.reverse) begin
      w_base_next = w_rev_diff[ADDR_W-1:0];
    end else begin
      w_base_next = w_fwd_sum[ADDR_W-1:0];
    end

    // Neighbour sits one word ahead in play direction, clamped at the clip edge.
    if (r_cfg.reverse) begin
      w_nbr = (r_base != '0) ? r_base - ADDR_W'(1) : r_base;
    end else begin
      w_nbr = (r_base < i_sram_stop_addr) ? r_base + ADDR_W'(1) : r_base;
    end

    w_sample = (r_cfg.is_slow && r_cfg.interp) ? w_interp : r_s0;
  end

  // s1 is taken straight off the read bus during CALC.
  aud_interp #(
    .DATA_W  (DATA_W),
    .SPEED_W (SPEED_W)
  ) u_interp (
    .i_s0     (r_s0),
    .i_s1     ($signed(i_sram_data)),
    .i_k      (r_k),
    .i_n      (w_n),
    .o_sample (w_interp)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_cfg        <= '0;
      r_base       <= '0;
      r_k          <= '0;
      r_s0         <= '0;
      r_pause_pend <= 1'b0;
      r_lrck_prev  <= 1'b0;
      r_dac_data   <= '0;
      r_dac_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_sram_addr  <= '0;
    end else begin
      r_lrck_prev <= i_daclrck;
      r_dac_valid <= 1'b0;
      r_done      <= 1'b0;

      if (i_stop) begin
        r_state      <= StIdle;
        r_pause_pend <= 1'b0;
        r_sram_addr  <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_sram_addr  <= '0;
            r_pause_pend <= 1'b0;
            if (i_start) begin
              r_state <= StWait;
              r_cfg   <= w_cfg_in;
              r_base  <= i_reverse ? i_sram_stop_addr : '0;
              r_k     <= '0;
            end
          end

          StPause: begin
            if (i_pause) begin
              r_state <= StWait;
              r_cfg   <= w_cfg_in;
            end
          end

          StWait: begin
            if (i_pause || r_pause_pend) begin
              r_state      <= StPause;
              r_pause_pend <= 1'b0;
            end else if (w_fall) begin
              r_state     <= StRd0;
              r_sram_addr <= r_base;
            end
          end

          StRd0: begin
            if (i_pause) r_pause_pend <= 1'b1;
            r_state     <= StRd1;
            r_sram_addr <= w_nbr;
          end

          StRd1: begin
            if (i_pause) r_pause_pend <= 1'b1;
            r_s0    <= i_sram_data;
            r_state <= StCalc;
          end

          StCalc: begin
            if (i_pause) r_pause_pend <= 1'b1;
            r_dac_data  <= w_sample;
            r_dac_valid <= 1'b1;
            r_k         <= w_k_next;
            r_base      <= w_base_next;
            if (w_end && !r_cfg.loop) begin
              r_done       <= 1'b1;
              r_state      <= StIdle;
              r_pause_pend <= 1'b0;
            end else begin
              r_state <= StWait;
            end
          end

          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_dac_data  = r_dac_data;
  assign o_dac_valid = r_dac_valid;
  assign o_is_pause  = (r_state == StPause);
  assign o_done      = r_done;
  assign o_sram_addr = r_sram_addr;

endmodule

// File: tb/tb_aud_dsp_param.sv
// Bench for aud_dsp_param: directed vector table, hand-written pause/stop/reset
// sequences, and randomized playback checked against a clip-level model.
module tb_aud_dsp_param;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_pause = 1'b0;
  logic          i_stop = 1'b0;
  logic [SW-1:0] i_speed = '0;
  logic          i_is_slow = 1'b0;
  logic          i_interp = 1'b0;
  logic          i_reverse = 1'b0;
  logic          i_loop = 1'b0;
  logic          i_daclrck = 1'b1;
  logic [DW-1:0] sram_data = '0;
  logic [AW-1:0] i_stop_addr = '0;
  logic [DW-1:0] o_dac_data;
  logic          o_dac_valid;
  logic          o_is_pause;
  logic          o_done;
  logic [AW-1:0] o_sram_addr;

  always #5 clk = ~clk;

  aud_dsp_param #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .SPEED_W (SW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_start          (i_start),
    .i_pause          (i_pause),
    .i_stop           (i_stop),
    .i_speed          (i_speed),
    .i_is_slow        (i_is_slow),
    .i_interp         (i_interp),
    .i_reverse        (i_reverse),
    .i_loop           (i_loop),
    .i_daclrck        (i_daclrck),
    .i_sram_data      (sram_data),
    .i_sram_stop_addr (i_stop_addr),
    .o_dac_data       (o_dac_data),
    .o_dac_valid      (o_dac_valid),
    .o_is_pause       (o_is_pause),
    .o_done           (o_done),
    .o_sram_addr      (o_sram_addr)
  );

  // SRAM: data for an address is valid the cycle after the address changes.
  logic signed [DW-1:0] mem [0:31];
  always @(posedge clk) sram_data <= mem[o_sram_addr[4:0]];

  int got_data[$];
  bit got_done[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (o_dac_valid) begin
      got_data.push_back(int'($signed(o_dac_data)));
      got_done.push_back(o_done);
    end
    if (o_done) done_cnt++;
  end

  int total = 0;
  int bad = 0;
  int exp_data[$];
  bit exp_done[$];
  int mark;
  int dmark;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One LR-clock period: high then falling; called and returns on a negedge.
  task automatic fall();
    i_daclrck = 1'b1;
    repeat (2) @(negedge clk);
    i_daclrck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic setup(input int speed, input bit slow, input bit interp, input bit rev,
                       input bit lp, input int stop);
    i_speed     = SW'(speed);
    i_is_slow   = slow;
    i_interp    = interp;
    i_reverse   = rev;
    i_loop      = lp;
    i_stop_addr = AW'(stop);
  endtask

  task automatic start_play();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    mark  = got_data.size();
    dmark = done_cnt;
  endtask

  task automatic halt();
    @(negedge clk) i_stop = 1'b1;
    @(negedge clk) i_stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Clip-level model: list every (address, phase) the clip visits once, then
  // replay that list (wrapping if looping) and interpolate where asked.
  task automatic build_model(input int n, input bit slow, input bit interp, input bit rev,
                             input bit lp, input int stop, input int req);
    int seq_a[$];
    int seq_k[$];
    int a;
    exp_data.delete();
    exp_done.delete();
    a = rev ? stop : 0;
    while (a >= 0 && a <= stop) begin
      for (int k = 0; k < (slow ? n : 1); k++) begin
        seq_a.push_back(a);
        seq_k.push_back(k);
      end
      a = rev ? a - (slow ? 1 : n) : a + (slow ? 1 : n);
    end
    for (int i = 0; i < req; i++) begin
      int idx, s0, s1, nb;
      if (!lp && i >= seq_a.size()) break;
      idx = i % seq_a.size();
      s0  = mem[seq_a[idx]];
      if (slow && interp) begin
        if (rev) nb = (seq_a[idx] > 0) ? seq_a[idx] - 1 : seq_a[idx];
        else     nb = (seq_a[idx] < stop) ? seq_a[idx] + 1 : seq_a[idx];
        s1 = mem[nb];
        exp_data.push_back(s0 + ((s1 - s0) * seq_k[idx]) / n);
      end else begin
        exp_data.push_back(s0);
      end
      exp_done.push_back(!lp && (i == seq_a.size() - 1));
    end
  endtask

  task automatic compare_run(input string tag);
    int ndone = 0;
    check($sformatf("%s count", tag), got_data.size() - mark, exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      if (exp_done[i]) ndone++;
      if (mark + i < got_data.size()) begin
        check($sformatf("%s data[%0d]", tag, i), got_data[mark + i], exp_data[i]);
        check($sformatf("%s done[%0d]", tag, i), int'(got_done[mark + i]), int'(exp_done[i]));
      end
    end
    check($sformatf("%s done pulses", tag), done_cnt - dmark, ndone);
  endtask

  typedef struct {
    int speed;
    bit slow;
    bit interp;
    bit rev;
    bit lp;
    int stop;
    int nout;
    int done_at;
    int exp [6];
  } vec_t;

  vec_t vecs [7];
  int   lin_exp [12];

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 6, -1, '{0, 100, 200, 300, 400, 500}};
    vecs[1] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 9, 4, 3, '{0, 300, 600, 900, 0, 0}};
    vecs[2] = '{2, 1'b0, 1'b0, 1'b1, 1'b1, 9, 6, -1, '{900, 600, 300, 0, 900, 600}};
    vecs[3] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 6, -1, '{0, 0, 100, 100, 200, 200}};
    vecs[4] = '{3, 1'b1, 1'b1, 1'b0, 1'b0, 9, 6, -1, '{0, 25, 50, 75, 100, 125}};
    vecs[5] = '{3, 1'b1, 1'b1, 1'b1, 1'b0, 9, 6, -1, '{900, 875, 850, 825, 800, 775}};
    vecs[6] = '{7, 1'b0, 1'b0, 1'b0, 1'b1, 9, 6, -1, '{0, 800, 0, 800, 0, 800}};
    lin_exp = '{0, 100, 200, 300, 400, 300, 200, 100, 0, 0, -1, -2};

    for (int i = 0; i < 32; i++) mem[i] = DW'(100 * i);

    // Reset state
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    check("rst dac_data", int'(o_dac_data), 0);
    check("rst dac_valid", int'(o_dac_valid), 0);
    check("rst is_pause", int'(o_is_pause), 0);
    check("rst done", int'(o_done), 0);
    check("rst sram_addr", int'(o_sram_addr), 0);

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      setup(vecs[v].speed, vecs[v].slow, vecs[v].interp, vecs[v].rev, vecs[v].lp,
            vecs[v].stop);
      start_play();
      repeat (6) fall();
      check($sformatf("vec%0d count", v), got_data.size() - mark, vecs[v].nout);
      for (int i = 0; i < vecs[v].nout; i++) begin
        if (mark + i < got_data.size()) begin
          check($sformatf("vec%0d data[%0d]", v, i), got_data[mark + i], vecs[v].exp[i]);
          check($sformatf("vec%0d done[%0d]", v, i), int'(got_done[mark + i]),
                int'(i == vecs[v].done_at));
        end
      end
      check($sformatf("vec%0d done pulses", v), done_cnt - dmark, (vecs[v].done_at >= 0) ? 1 : 0);
      halt();
    end

    // Full forward clip ends with one done pulse and returns to idle
    setup(0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    start_play();
    repeat (11) fall();
    build_model(1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 11);
    compare_run("fwd_full");
    check("fwd_full last", (got_data.size() >= mark + 10) ? got_data[mark + 9] : -1, 900);
    check("fwd_full idle addr", int'(o_sram_addr), 0);
    @(negedge clk) i_pause = 1'b1;
    @(negedge clk) i_pause = 1'b0;
    check("idle pause ignored", int'(o_is_pause), 0);

    // Slow linear interpolation including rounding toward zero on negative diffs
    mem[0] = 16'sd0;
    mem[1] = 16'sd400;
    mem[2] = 16'sd0;
    mem[3] = -16'sd3;
    setup(3, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    start_play();
    repeat (12) fall();
    check("lin count", got_data.size() - mark, 12);
    for (int i = 0; i < 12; i++) begin
      if (mark + i < got_data.size())
        check($sformatf("lin data[%0d]", i), got_data[mark + i], lin_exp[i]);
    end
    halt();
    for (int i = 0; i < 32; i++) mem[i] = DW'(100 * i);

    // Pause arriving while RD1 is in flight
    setup(0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    start_play();
    i_daclrck = 1'b1;
    repeat (2) @(negedge clk);
    i_daclrck = 1'b0;
    @(negedge clk);
    @(negedge clk) i_pause = 1'b1;
    @(negedge clk) i_pause = 1'b0;
    check("pause in-flight is_pause", int'(o_is_pause), 0);
    @(negedge clk);
    check("pause sample valid", int'(o_dac_valid), 1);
    check("pause sample data", int'(o_dac_data), 0);
    @(negedge clk);
    check("pause entered", int'(o_is_pause), 1);
    mark = got_data.size();
    fall();
    fall();
    check("paused no output", got_data.size() - mark, 0);
    check("paused holds", int'(o_is_pause), 1);
    @(negedge clk) i_pause = 1'b1;
    @(negedge clk) i_pause = 1'b0;
    check("resume is_pause", int'(o_is_pause), 0);
    fall();
    check("resume count", got_data.size() - mark, 1);
    check("resume data", (got_data.size() > mark) ? got_data[mark] : -1, 100);
    halt();

    // Stop beats pause in the same cycle
    start_play();
    @(negedge clk) begin i_stop = 1'b1; i_pause = 1'b1; end
    @(negedge clk) begin i_stop = 1'b0; i_pause = 1'b0; end
    check("stop+pause is_pause", int'(o_is_pause), 0);
    check("stop+pause addr", int'(o_sram_addr), 0);
    fall();
    check("stop+pause no output", got_data.size() - mark, 0);
    check("stop+pause no done", done_cnt - dmark, 0);

    // Reset while a sample is in CALC
    start_play();
    fall();
    fall();
    check("pre-reset data", int'(o_dac_data), 100);
    i_daclrck = 1'b1;
    repeat (2) @(negedge clk);
    i_daclrck = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("calc rst dac_data", int'(o_dac_data), 0);
    check("calc rst dac_valid", int'(o_dac_valid), 0);
    check("calc rst is_pause", int'(o_is_pause), 0);
    check("calc rst done", int'(o_done), 0);
    check("calc rst sram_addr", int'(o_sram_addr), 0);
    repeat (2) @(negedge clk);

    // Randomized playback against the clip-level model
    for (int r = 0; r < 20; r++) begin
      int sp, st, req;
      bit sl, it, rv, lp;
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
      sp  = $urandom_range(0, 7);
      st  = $urandom_range(1, 12);
      sl  = 1'($urandom_range(0, 1));
      it  = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      lp  = 1'($urandom_range(0, 1));
      req = $urandom_range(8, 30);
      setup(sp, sl, it, rv, lp, st);
      start_play();
      repeat (req) fall();
      build_model(sp + 1, sl, it, rv, lp, st, req);
      compare_run($sformatf("rand%0d", r));
      halt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
